// File: rtl/store_queue_ctrl_if.sv
// store_queue_ctrl_if: execute-side store channel, memory write port and fence signals
interface store_queue_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_sb;
    logic              st_sh;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic              fence_req;
    logic              fence_done;
    logic              misalign_err;
    logic [CW-1:0]     count;

    modport master (
        output st_valid, st_addr, st_data, st_sb, st_sh, mem_ack, fence_req,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, fence_done, misalign_err, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_sb, st_sh, mem_ack, fence_req,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be, fence_done, misalign_err, count
    );
endinterface

// File: rtl/store_queue_ctrl.sv
// store_queue_ctrl: in-order store FIFO with lane placement and req/ack memory issue
module store_queue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    store_queue_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [3:0]        r_be   [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic [0:0]        r_state;
    logic              r_mis;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_be;

    logic              w_byte;
    logic              w_half;
    logic              w_word;
    logic              w_mis;
    logic              w_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_go;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic [CW-1:0]     w_rem;
    logic [PW-1:0]     w_head;

    assign bus.st_ready     = (r_count != CW'(DEPTH)) && !bus.fence_req;
    assign bus.mem_req      = (r_state == S_ISSUE);
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_be       = r_mem_be;
    assign bus.misalign_err = r_mis;
    assign bus.count        = r_count;
    assign bus.fence_done   = bus.fence_req && (r_count == '0) && (r_state == S_IDLE);

    // Decode size, place lanes, and pick the entry the memory port shows next.
    // When the queue would otherwise be empty the incoming store goes straight
    // to the output registers so an idle queue issues one cycle after the push.
    always_comb begin
        w_byte  = bus.st_sb && !bus.st_sh;
        w_half  = bus.st_sh && !bus.st_sb;
        w_word  = !w_byte && !w_half;
        w_mis   = (w_half && bus.st_addr[0]) || (w_word && (bus.st_addr[1:0] != 2'b00));
        w_addr  = {bus.st_addr[ADDR_W-1:2], 2'b00};
        w_wdata = w_byte ? {4{bus.st_data[7:0]}} : w_half ? {2{bus.st_data[15:0]}} : bus.st_data;
        w_be    = w_byte ? (4'b0001 << bus.st_addr[1:0]) : w_half ? (bus.st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_fire  = bus.st_valid && bus.st_ready;
        w_push  = w_fire && !w_mis;
        w_pop   = (r_state == S_ISSUE) && bus.mem_ack;
        w_rem   = r_count - CW'(w_pop);
        w_head  = r_rd + PW'(w_pop);
        w_go    = (w_rem != '0) || w_push;
    end

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr] <= w_addr;
            r_data[r_wr] <= w_wdata;
            r_be[r_wr]   <= w_be;
        end
    end

    // Pointers, occupancy, issue FSM and registered memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_state     <= S_IDLE;
            r_mis       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_mis   <= w_fire && w_mis;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            if ((r_state == S_IDLE) || w_pop) begin
                r_state <= w_go ? S_ISSUE : S_IDLE;
                if (w_go) begin
                    r_mem_addr  <= (w_rem != '0) ? r_addr[w_head] : w_addr;
                    r_mem_wdata <= (w_rem != '0) ? r_data[w_head] : w_wdata;
                    r_mem_be    <= (w_rem != '0) ? r_be[w_head] : w_be;
                end
            end
        end
    end
endmodule

// File: tb/tb_store_queue_ctrl.sv
// tb_store_queue_ctrl: scoreboard bench with a queue-level reference model
module tb_store_queue_ctrl;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    int     checks = 0;
    int     errors = 0;
    int     exp_count = 0;
    logic   exp_mis = 1'b0;
    entry_t sb[$];

    store_queue_ctrl_if #(.ADDR_W(32), .DEPTH(DEPTH)) bus ();

    store_queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int size_of(input logic b, input logic h);
        return (b && !h) ? 1 : (h && !b) ? 2 : 4;
    endfunction

    function automatic entry_t place(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
        entry_t e;
        int sz;
        sz = size_of(b, h);
        e.addr = a & ~32'h3;
        e.wdata = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
        e.be = 4'(((1 << sz) - 1) << (a % 4));
        return e;
    endfunction

    // Reference model: accepted stores become expected writes; each acked cycle retires one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_count = 0;
            exp_mis = 1'b0;
            sb.delete();
        end else begin
            logic acc;
            logic bad;
            logic pop;
            acc = bus.st_valid && (exp_count < DEPTH) && !bus.fence_req;
            bad = (bus.st_addr % size_of(bus.st_sb, bus.st_sh)) != 0;
            pop = (exp_count > 0) && bus.mem_ack;
            exp_mis = acc && bad;
            if (acc && !bad) begin
                sb.push_back(place(bus.st_addr, bus.st_data, bus.st_sb, bus.st_sh));
                exp_count++;
            end
            if (pop) exp_count--;
        end
    end

    // Monitor: compare the DUT against the model mid-cycle and retire acked writes.
    always @(negedge clk) begin
        chk("count", 64'(bus.count), 64'(exp_count));
        chk("mem_req", 64'(bus.mem_req), 64'(exp_count != 0));
        chk("st_ready", 64'(bus.st_ready), 64'((exp_count < DEPTH) && !bus.fence_req));
        chk("fence_done", 64'(bus.fence_done), 64'(bus.fence_req && exp_count == 0));
        chk("misalign_err", 64'(bus.misalign_err), 64'(exp_mis));
        if (exp_count != 0) begin
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 64'(0), 64'(1));
            end else begin
                chk("mem_addr", 64'(bus.mem_addr), 64'(sb[0].addr));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(sb[0].wdata));
                chk("mem_be", 64'(bus.mem_be), 64'(sb[0].be));
                if (bus.mem_ack) void'(sb.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
        bus.st_valid = v;
        bus.st_addr = a;
        bus.st_data = d;
        bus.st_sb = b;
        bus.st_sh = h;
    endtask

    initial begin
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.mem_ack = 1'b0;
        bus.fence_req = 1'b0;
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'h0);
        chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        chk("reset_mem_be", 64'(bus.mem_be), 64'h0);
        chk("reset_st_ready", 64'(bus.st_ready), 64'h1);
        chk("reset_fence_done", 64'(bus.fence_done), 64'h0);

        bus.mem_ack = 1'b1;
        put(1'b1, 32'h1003, 32'hAABBCCDD, 1'b1, 1'b0);
        cyc();
        chk("byte_addr", 64'(bus.mem_addr), 64'h1000);
        chk("byte_be", 64'(bus.mem_be), 64'b1000);
        chk("byte_wdata", 64'(bus.mem_wdata), 64'hDDDDDDDD);
        put(1'b1, 32'h1002, 32'h00001234, 1'b0, 1'b1);
        cyc();
        chk("half_be", 64'(bus.mem_be), 64'b1100);
        chk("half_wdata", 64'(bus.mem_wdata), 64'h12341234);
        put(1'b1, 32'h2000, 32'hCAFEF00D, 1'b0, 1'b0);
        cyc();
        chk("word_be", 64'(bus.mem_be), 64'b1111);
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();

        put(1'b1, 32'h1001, 32'h5555, 1'b0, 1'b1);
        cyc();
        put(1'b1, 32'h1002, 32'h66666666, 1'b0, 1'b0);
        cyc();
        chk("misalign_pulse", 64'(bus.misalign_err), 64'h1);
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("misalign_count", 64'(bus.count), 64'h0);
        cyc();

        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 32'h3000 + 32'(i * 4), 32'h11110000 + 32'(i), 1'b0, 1'b0);
            cyc();
        end
        chk("full_ready", 64'(bus.st_ready), 64'h0);
        chk("full_count", 64'(bus.count), 64'h4);
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.mem_ack = 1'b1;
        repeat (5) cyc();
        chk("drained_count", 64'(bus.count), 64'h0);

        bus.mem_ack = 1'b0;
        put(1'b1, 32'h4004, 32'h0BADBEEF, 1'b0, 1'b0);
        cyc();
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) cyc();
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        cyc();
        chk("wait_single_pop", 64'(bus.count), 64'h0);

        put(1'b1, 32'h5000, 32'h01020304, 1'b0, 1'b0);
        cyc();
        put(1'b1, 32'h5006, 32'h0000BEEF, 1'b0, 1'b1);
        cyc();
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.fence_req = 1'b1;
        #1;
        chk("fence_blocks_ready", 64'(bus.st_ready), 64'h0);
        chk("fence_not_done", 64'(bus.fence_done), 64'h0);
        bus.mem_ack = 1'b1;
        cyc();
        #1 chk("fence_one_left", 64'(bus.fence_done), 64'h0);
        cyc();
        #1 chk("fence_done", 64'(bus.fence_done), 64'h1);
        bus.fence_req = 1'b0;
        #1 chk("fence_release_ready", 64'(bus.st_ready), 64'h1);
        cyc();

        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 32'h6000 + 32'(i * 4), 32'h77770000 + 32'(i), 1'b0, 1'b0);
            cyc();
        end
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_req", 64'(bus.mem_req), 64'h0);
        chk("async_reset_count", 64'(bus.count), 64'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_ready", 64'(bus.st_ready), 64'h1);

        for (int i = 0; i < 600; i++) begin
            put(1'($urandom_range(0, 1)), 32'h8000 + 32'($urandom_range(0, 63)), $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.mem_ack = ($urandom_range(0, 2) != 0);
            bus.fence_req = ($urandom_range(0, 15) == 0);
            cyc();
        end
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.fence_req = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (8) cyc();
        chk("final_empty", 64'(bus.count), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_queue_ctrl.md
# store_queue_ctrl

Store-path controller between the execute stage and the data memory write port. Accepts store requests (address, register data, `sb`/`sh` size flags) and performs lane placement and byte-enable generation. Buffers requests in a small in-order FIFO and issues them to memory over a req/ack handshake. Provides pipeline back-pressure, misalignment rejection and a fence/drain handshake.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  store request present this cycle.
- `st_ready`  out  1  queue accepts request. Transfer when `st_valid && st_ready`.
- `st_addr`  in  ADDR_W  byte address.
- `st_data`  in  32  unmodified source register.
- `st_sb`  in  1  byte store.
- `st_sh`  in  1  halfword store. `{sb,sh}`=00 or 11 means word store.
- `mem_req`  out  1  write request to memory.
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0]=0.
- `mem_wdata`  out  32  lane-placed write data.
- `mem_be`  out  4  byte enables; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_ack`  in  1  memory accepted current request.
- `fence_req`  in  1  level; drain queue and block new stores.
- `fence_done`  out  1  queue empty while `fence_req` high.
- `misalign_err`  out  1  one-cycle pulse: rejected misaligned store.
- `count`  out  clog2(DEPTH+1)  valid entries.

## Operation
- Lane placement happens at enqueue. The entry stores `{word_addr, wdata, be}`.
  - Byte (`sb`=1, `sh`=0): `wdata={4{st_data[7:0]}}`, `be=4'b0001<<addr[1:0]`.
  - Half: `wdata={2{st_data[15:0]}}`. `be=0011` if `addr[1]`=0, else `1100`.
  - Word: `wdata=st_data`, `be=1111`.
- Misalignment: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Request is still consumed (handshake completes) but not enqueued.
  - `misalign_err` pulses high the following cycle.
  - `count` and the FIFO are unchanged.
- `st_ready = !full && !fence_req`. This is combinational; there is no pass-through when full, even if a pop happens the same cycle.
- FSM states:
  - IDLE: `mem_req`=0. Go to ISSUE when FIFO is non-empty.
  - ISSUE: `mem_req`=1, and `mem_addr`/`mem_wdata`/`mem_be` show the FIFO head, held stable until ack.
  - On `mem_ack`=1 in ISSUE: pop the head.
    - If entries remain (counting a same-cycle push), stay in ISSUE; the next head is presented the next cycle, so requests run back-to-back.
    - Otherwise go to IDLE.
  - `mem_ack` in IDLE is ignored.
- Simultaneous push and pop: `count` is unchanged; pointers wrap modulo `DEPTH`.
- Ordering is strictly FIFO.
- Fence:
  - While `fence_req`=1, no enqueue occurs.
  - `fence_done = fence_req && count==0 && state==IDLE`.
  - Dropping `fence_req` restores `st_ready` the same cycle.

## Timing
- Reset (async assert, sync release) gives:
  - outputs: `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `misalign_err`=0, `count`=0;
  - state IDLE, FIFO empty;
  - `st_ready`=1 and `fence_done`=0 when `fence_req`=0.
- Reset mid-transfer drops `mem_req` immediately. The outstanding write and all queued entries are discarded.
- `mem_*` outputs are registered.
- Latency: a push at edge N gives `mem_req`=1 in cycle N+1 (empty queue, IDLE).
- Throughput: one store per cycle when `mem_ack` is held high.
- `count` updates at the edge of push/pop.
- `misalign_err` is high in cycle N+1 for a rejected transfer at edge N.

## Test plan
- Lane placement. Push byte addr 0x1003 data 0xAABBCCDD, ack immediately.
  - Expect `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xDDDDDDDD.
  - Half addr 0x1002 data 0x1234: expect `be`=1100, `wdata`=0x12341234.
  - Word 0x2000: expect `be`=1111.
- Misalign. Push half addr 0x1001, then word addr 0x1002.
  - Expect two `misalign_err` pulses, `count` stays 0, `mem_req` never rises.
- Full / back-pressure. Hold `mem_ack`=0 and push 5 words.
  - Expect `st_ready`=0 after the 4th push and `count`=4.
  - Then ack each cycle: writes drain in push order, back-to-back, `mem_req` continuous for 4 cycles.
- Wait states. One store with `mem_ack` low for 3 cycles.
  - Expect `mem_addr`/`mem_wdata`/`mem_be` stable across all 4 request cycles and a single pop.
- Fence. Queue 2 stores, assert `fence_req`.
  - Expect `st_ready`=0 immediately.
  - `fence_done`=1 only after the second ack, with the FSM in IDLE.
  - Deasserting `fence_req` restores `st_ready`=1.
- Reset mid-operation. 3 entries queued, `mem_req`=1, pulse `rst_n` low.
  - Expect `mem_req`=0 asynchronously, `count`=0, and `st_ready`=1 after release.
